instruction_fetch_unit: RTL and testbench

- Supplies `instr_current` to the instruction decoder and acts on its fetch/PC control strobes (`instr_rd_en`, `instr_flush`, `pc_incr_en`, `pc_j_en`).
- Owns the 13-bit program counter, the instruction register, the program-memory address port and an 8-level hardware return stack.
- Sits between program memory and the decoder. Provides the one-instruction prefetch pipeline: execute N while N+1 is fetched.

---
 rtl/instruction_fetch_unit_pkg.sv | 19 +
 rtl/return_stack.sv | 57 +++++
 rtl/instruction_fetch_unit.sv | 91 +++++++++
 tb/tb_instruction_fetch_unit.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// ISA-level constants shared by the fetch unit and the instruction decoder.
//   PC_WIDTH     program counter / program memory address width
//   INSTR_WIDTH  instruction word width
//   STACK_DEPTH  hardware return stack entries
//   NOP_WORD     word held in the instruction register after flush/reset
// Also holds the field widths used to assemble PC jump and PCL-write targets.
package instruction_fetch_unit_pkg;

  localparam int PC_WIDTH    = 13;
  localparam int INSTR_WIDTH = 14;
  localparam int STACK_DEPTH = 8;
  localparam logic [INSTR_WIDTH-1:0] NOP_WORD = 14'h0000;

  // GOTO/CALL carry an 11-bit literal; PCLATH[4:3] supplies the page bits.
  localparam int JMP_LIT_W = 11;
  localparam int PCLATH_W  = 5;
  localparam int PCL_W     = 8;

endpackage

// File: rtl/return_stack.sv
// Circular hardware return stack.
//   clk, rst    clock, synchronous active-high reset
//   push, pop   push din / pop top (pop wins if both are high)
//   din         value to push
//   top         entry the next pop will return (entry below the pointer)
//   ovf, unf    sticky overflow / underflow flags
// The pointer wraps modulo DEPTH so a push on a full stack silently
// overwrites the oldest entry; count only tracks validity for the flags.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             ovf,
  output logic             unf
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               ptr;
  logic [PW-1:0]               ptr_dec;
  logic [PW:0]                 cnt;

  assign ptr_dec = ptr - 1'b1;
  assign top     = mem[ptr_dec];

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (pop) begin
      // Empty pop still moves the pointer; the caller loads the wrapped entry.
      ptr <= ptr_dec;
      if (cnt == '0) unf <= 1'b1;
      else           cnt <= cnt - 1'b1;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (cnt == FULL) ovf <= 1'b1;
      else             cnt <= cnt + 1'b1;
    end
  end

  // Contents are don't-care after reset, so storage carries no reset.
  always_ff @(posedge clk) begin
    if (!rst && push && !pop) mem[ptr] <= din;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: program counter, instruction register, program
// memory address port and the return stack.
//   clk, rst       clock, synchronous active-high reset
//   prog_addr      program memory address (= PC)
//   prog_data      program memory word at prog_addr
//   instr_current  instruction register, to the decoder
//   instr_rd_en    load prog_data into the instruction register
//   instr_flush    load NOP_WORD (wins over instr_rd_en)
//   pc_incr_en     PC <= PC+1
//   pc_j_en        PC <= {pclath[4:3], instr_current[10:0]}
//   push_en        push current PC (CALL)
//   pop_en         PC <= stack top (RETURN family)
//   pcl_wr_en      PC <= {pclath, pcl_wr_data}
//   pcl            PC[7:0]
//   stack_ovf/unf  sticky stack overflow / underflow
// PC priority: rst > pop > jump > PCL write > increment > hold.
module instruction_fetch_unit #(
  parameter int PC_WIDTH    = instruction_fetch_unit_pkg::PC_WIDTH,
  parameter int INSTR_WIDTH = instruction_fetch_unit_pkg::INSTR_WIDTH,
  parameter int STACK_DEPTH = instruction_fetch_unit_pkg::STACK_DEPTH,
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD = instruction_fetch_unit_pkg::NOP_WORD
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [PC_WIDTH-1:0]    prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  output logic [INSTR_WIDTH-1:0] instr_current,
  input  logic                   instr_rd_en,
  input  logic                   instr_flush,
  input  logic                   pc_incr_en,
  input  logic                   pc_j_en,
  input  logic                   push_en,
  input  logic                   pop_en,
  input  logic                   pcl_wr_en,
  input  logic [7:0]             pcl_wr_data,
  input  logic [4:0]             pclath,
  output logic [7:0]             pcl,
  output logic                   stack_ovf,
  output logic                   stack_unf
);

  import instruction_fetch_unit_pkg::*;

  logic [PC_WIDTH-1:0]    pc, pc_nxt, stk_top;
  logic [INSTR_WIDTH-1:0] ir;

  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (push_en),
    .pop  (pop_en),
    .din  (pc),
    .top  (stk_top),
    .ovf  (stack_ovf),
    .unf  (stack_unf)
  );

  always_comb begin
    pc_nxt = pc;
    if (pop_en)
      pc_nxt = stk_top;
    else if (pc_j_en)
      pc_nxt = PC_WIDTH'({pclath[PCLATH_W-1:PCLATH_W-2], ir[JMP_LIT_W-1:0]});
    else if (pcl_wr_en)
      pc_nxt = PC_WIDTH'({pclath, pcl_wr_data});
    else if (pc_incr_en)
      pc_nxt = pc + 1'b1;  // natural wrap at the top of the address space
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= '0;
      ir <= NOP_WORD;
    end else begin
      pc <= pc_nxt;
      if (instr_flush)      ir <= NOP_WORD;
      else if (instr_rd_en) ir <= prog_data;
    end
  end

  assign prog_addr     = pc;
  assign pcl           = pc[PCL_W-1:0];
  assign instr_current = ir;

  // Decoder must never request push and pop together; hardware pops only.
  a_no_push_pop: assert property (@(posedge clk) disable iff (rst) !(push_en && pop_en));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] prog_addr;
  logic [13:0] prog_data;
  logic [13:0] instr_current;
  logic        instr_rd_en, instr_flush, pc_incr_en, pc_j_en;
  logic        push_en, pop_en, pcl_wr_en;
  logic [7:0]  pcl_wr_data;
  logic [4:0]  pclath;
  logic [7:0]  pcl;
  logic        stack_ovf, stack_unf;

  logic [13:0] rom [0:8191];
  assign prog_data = rom[prog_addr];

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .rst(rst), .prog_addr(prog_addr), .prog_data(prog_data),
    .instr_current(instr_current), .instr_rd_en(instr_rd_en),
    .instr_flush(instr_flush), .pc_incr_en(pc_incr_en), .pc_j_en(pc_j_en),
    .push_en(push_en), .pop_en(pop_en), .pcl_wr_en(pcl_wr_en),
    .pcl_wr_data(pcl_wr_data), .pclath(pclath), .pcl(pcl),
    .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: the return stack is a bounded LIFO queue of return
  // addresses; overflow drops the oldest one.
  logic [12:0] m_pc;
  logic [13:0] m_ir;
  logic        m_ovf, m_unf;
  bit          m_known;
  logic [12:0] m_stk [$];

  task automatic model_upd();
    logic [12:0] npc;
    logic [13:0] nir;
    if (rst) begin
      m_pc = '0; m_ir = NOP_WORD; m_ovf = 1'b0; m_unf = 1'b0;
      m_stk.delete(); m_known = 1'b1;
    end else begin
      npc = m_pc;
      nir = m_ir;
      if (pop_en) begin
        if (m_stk.size() == 0) begin
          m_unf = 1'b1;
          m_known = 1'b0;  // stale entry; checked directly where it matters
        end else npc = m_stk.pop_back();
      end else if (pc_j_en)    npc = {pclath[4:3], m_ir[10:0]};
      else if (pcl_wr_en)      npc = {pclath, pcl_wr_data};
      else if (pc_incr_en)     npc = (m_pc == 13'h1FFF) ? 13'h0 : m_pc + 13'd1;
      if (push_en && !pop_en) begin
        if (m_stk.size() == STACK_DEPTH) begin
          m_ovf = 1'b1;
          void'(m_stk.pop_front());
        end
        m_stk.push_back(m_pc);
      end
      if (instr_flush)      nir = NOP_WORD;
      else if (instr_rd_en) nir = rom[m_pc];
      m_pc = npc;
      m_ir = nir;
    end
  endtask

  task automatic idle();
    rst = 1'b0; instr_rd_en = 1'b0; instr_flush = 1'b0; pc_incr_en = 1'b0;
    pc_j_en = 1'b0; push_en = 1'b0; pop_en = 1'b0; pcl_wr_en = 1'b0;
  endtask

  // One clock with the currently driven inputs, then compare against the model.
  task automatic step();
    @(posedge clk);
    #1;
    model_upd();
    if (m_known) begin
      chk("pc",  32'(prog_addr),     32'(m_pc));
      chk("pcl", 32'(pcl),           32'(m_pc[7:0]));
      chk("ir",  32'(instr_current), 32'(m_ir));
    end
    chk("ovf", 32'(stack_ovf), 32'(m_ovf));
    chk("unf", 32'(stack_unf), 32'(m_unf));
  endtask

  initial begin
    for (int a = 0; a < 8192; a++) rom[a] = 14'($urandom);
    m_known = 1'b0; m_pc = '0; m_ir = '0; m_ovf = 1'b0; m_unf = 1'b0;
    idle();
    pclath = '0; pcl_wr_data = '0;

    // Reset
    rst = 1'b1; step(); step();
    chk("rst_pc", 32'(prog_addr), 0);
    chk("rst_ir", 32'(instr_current), 0);
    chk("rst_flags", 32'({stack_ovf, stack_unf}), 0);
    idle();

    // Fetch rhythm: three rd+incr pulses, four cycles apart
    rom[0] = 14'h3005; rom[1] = 14'h0080; rom[2] = 14'h2804;
    begin
      logic [13:0] exp_ir [3];
      exp_ir[0] = 14'h3005; exp_ir[1] = 14'h0080; exp_ir[2] = 14'h2804;
      for (int k = 0; k < 3; k++) begin
        instr_rd_en = 1'b1; pc_incr_en = 1'b1; step();
        chk("fetch_ir", 32'(instr_current), 32'(exp_ir[k]));
        idle(); step(); step(); step();
      end
    end
    chk("fetch_pc", 32'(prog_addr), 3);

    // GOTO with page bits from PCLATH
    rom[3] = 14'h2A34;
    instr_rd_en = 1'b1; step(); idle();
    pclath = 5'b01000; instr_flush = 1'b1; pc_j_en = 1'b1; step(); idle();
    chk("goto_pc",  32'(prog_addr), 32'h0A34);
    chk("goto_ir",  32'(instr_current), 0);
    chk("goto_pcl", 32'(pcl), 32'h34);

    // CALL / RETURN
    pclath = 5'h0; pcl_wr_en = 1'b1; pcl_wr_data = 8'h10; step(); idle();
    rom[13'h10] = 14'h2100;
    instr_rd_en = 1'b1; step(); idle();
    push_en = 1'b1; pc_j_en = 1'b1; instr_flush = 1'b1; step(); idle();
    chk("call_pc", 32'(prog_addr), 32'h0100);
    step(); step();
    pop_en = 1'b1; instr_flush = 1'b1; step(); idle();
    chk("ret_pc", 32'(prog_addr), 32'h0010);
    chk("ret_flags", 32'({stack_ovf, stack_unf}), 0);

    // Overflow then underflow
    rst = 1'b1; step(); idle();
    pc_incr_en = 1'b1; step();
    push_en = 1'b1;
    for (int k = 0; k < 9; k++) step();
    idle();
    for (int k = 0; k < 8; k++) begin
      pop_en = 1'b1; step();
      chk("pop_pc", 32'(prog_addr), 32'(9 - k));
    end
    chk("ovf_set", 32'(stack_ovf), 1);
    chk("unf_clr", 32'(stack_unf), 0);
    pop_en = 1'b1; step(); idle();
    chk("unf_pc", 32'(prog_addr), 9);
    chk("unf_set", 32'(stack_unf), 1);

    // Reset one cycle after a jump
    pc_j_en = 1'b1; step(); idle();
    rst = 1'b1; step(); idle();
    chk("rst2_pc", 32'(prog_addr), 0);
    chk("rst2_flags", 32'({stack_ovf, stack_unf}), 0);

    // PCL write to the top of memory, then wrap on increment
    pclath = 5'h1F; pcl_wr_en = 1'b1; pcl_wr_data = 8'hFF; step(); idle();
    chk("pcl_wr_pc", 32'(prog_addr), 32'h1FFF);
    pc_incr_en = 1'b1; step(); idle();
    chk("wrap_pc", 32'(prog_addr), 0);

    // Flush beats read
    instr_rd_en = 1'b1; step();
    instr_flush = 1'b1; step(); idle();
    chk("flush_ir", 32'(instr_current), 0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      idle();
      rst         = ($urandom_range(0, 199) == 0);
      instr_flush = ($urandom_range(0, 3) == 0);
      instr_rd_en = 1'($urandom);
      pc_incr_en  = 1'($urandom);
      pc_j_en     = ($urandom_range(0, 7) == 0);
      push_en     = (pc_j_en && 1'($urandom)) || ($urandom_range(0, 15) == 0);
      pop_en      = !push_en && (m_stk.size() > 0) && ($urandom_range(0, 5) == 0);
      pcl_wr_en   = ($urandom_range(0, 15) == 0);
      pcl_wr_data = 8'($urandom);
      pclath      = 5'($urandom);
      step();
    end
    idle(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
